// File: rtl/bk_pkg.sv
// Shared Brent-Kung types and the prefix merge rule used by every black-dot cell.
package bk_pkg;

  localparam int BK_WIDTH = 16;

  // Group generate/propagate pair; g sits in the upper bit of the packed struct.
  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  // Combine a high group with the adjacent low group into one wider group.
  function automatic gp_t gp_merge_f(gp_t hi, gp_t lo);
    gp_t res;
    res.g = hi.g | (hi.p & lo.g);
    res.p = hi.p & lo.p;
    return res;
  endfunction

endpackage

// File: rtl/gp_merge.sv
// One Brent-Kung black-dot cell: merges a high (g,p) group with the low group below it.
module gp_merge
  import bk_pkg::*;
(
  input  logic gH,
  input  logic pH,
  input  logic gL,
  input  logic pL,
  output logic G,
  output logic P
);

  gp_t hiGp;
  gp_t loGp;
  gp_t outGp;

  assign hiGp  = '{g: gH, p: pH};
  assign loGp  = '{g: gL, p: pL};
  assign outGp = gp_merge_f(hiGp, loGp);
  assign G     = outGp.g;
  assign P     = outGp.p;

endmodule

// File: rtl/bk_sub_pipe.sv
// Two-stage pipelined subtractor D = A - B - Bin built as A + ~B + ~Bin on a
// Brent-Kung prefix network. Stage 1 registers the bitwise terms and the first
// two up-sweep levels; stage 2 finishes the up-sweep, runs the down-sweep and
// registers the difference, borrow out and signed overflow. Both stages hand
// data forward over valid/ready with full-rate simultaneous load and drain.
// WIDTH must be a power of two and at least 4 so that two up-sweep levels
// always fit inside stage 1.
module bk_sub_pipe
  import bk_pkg::*;
#(
  parameter int WIDTH = BK_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             V
);

  localparam int LOG_W = $clog2(WIDTH);

  // ---------------------------------------------------------------------------
  // Handshake control
  // ---------------------------------------------------------------------------
  logic s1Valid_q, s1Valid_d;
  logic s2Valid_q, s2Valid_d;
  logic s1Load;
  logic s2Load;

  assign s2Load    = s1Valid_q && (!s2Valid_q || out_ready);
  assign in_ready  = !s1Valid_q || s2Load;
  assign s1Load    = in_valid && in_ready;
  assign out_valid = s2Valid_q;

  // ---------------------------------------------------------------------------
  // Stage 1 combinational: bitwise terms of A + ~B and up-sweep levels 1 and 2
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] bitG;
  logic [WIDTH-1:0] bitP;

  assign bitG = A & ~B;
  assign bitP = A ^ ~B;

  for (genvar lvl = 1; lvl <= 2; lvl++) begin : gS1Up
    logic [WIDTH-1:0] inG;
    logic [WIDTH-1:0] inP;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;

    if (lvl == 1) begin : gSrc
      assign inG = bitG;
      assign inP = bitP;
    end else begin : gSrc
      assign inG = gS1Up[lvl-1].g;
      assign inP = gS1Up[lvl-1].p;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : gNode
      if (((i + 1) % (1 << lvl)) == 0) begin : gCell
        gp_merge uCell (
          .gH(inG[i]),
          .pH(inP[i]),
          .gL(inG[i - (1 << (lvl - 1))]),
          .pL(inP[i - (1 << (lvl - 1))]),
          .G (g[i]),
          .P (p[i])
        );
      end else begin : gCell
        assign g[i] = inG[i];
        assign p[i] = inP[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1 registers
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] s1P_q,    s1P_d;
  logic [WIDTH-1:0] s1G2_q,   s1G2_d;
  logic [WIDTH-1:0] s1P2_q,   s1P2_d;
  logic             s1C0_q,   s1C0_d;
  logic             s1AMsb_q, s1AMsb_d;
  logic             s1BMsb_q, s1BMsb_d;

  // Capture a new operand beat, or drop the valid flag once stage 2 takes it.
  always_comb begin
    s1Valid_d = s1Valid_q;
    s1P_d     = s1P_q;
    s1G2_d    = s1G2_q;
    s1P2_d    = s1P2_q;
    s1C0_d    = s1C0_q;
    s1AMsb_d  = s1AMsb_q;
    s1BMsb_d  = s1BMsb_q;
    if (s1Load) begin
      s1Valid_d = 1'b1;
      s1P_d     = bitP;
      s1G2_d    = gS1Up[2].g;
      s1P2_d    = gS1Up[2].p;
      s1C0_d    = ~Bin;
      s1AMsb_d  = A[WIDTH-1];
      s1BMsb_d  = B[WIDTH-1];
    end else if (s2Load) begin
      s1Valid_d = 1'b0;
    end
  end

  // Stage 1 state, cleared on reset so a stalled beat never survives it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1Valid_q <= 1'b0;
      s1P_q     <= '0;
      s1G2_q    <= '0;
      s1P2_q    <= '0;
      s1C0_q    <= 1'b0;
      s1AMsb_q  <= 1'b0;
      s1BMsb_q  <= 1'b0;
    end else begin
      s1Valid_q <= s1Valid_d;
      s1P_q     <= s1P_d;
      s1G2_q    <= s1G2_d;
      s1P2_q    <= s1P2_d;
      s1C0_q    <= s1C0_d;
      s1AMsb_q  <= s1AMsb_d;
      s1BMsb_q  <= s1BMsb_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2 combinational: remaining up-sweep levels (3 .. LOG_W)
  // ---------------------------------------------------------------------------
  for (genvar lvl = 3; lvl <= LOG_W; lvl++) begin : gS2Up
    logic [WIDTH-1:0] inG;
    logic [WIDTH-1:0] inP;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;

    if (lvl == 3) begin : gSrc
      assign inG = s1G2_q;
      assign inP = s1P2_q;
    end else begin : gSrc
      assign inG = gS2Up[lvl-1].g;
      assign inP = gS2Up[lvl-1].p;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : gNode
      if (((i + 1) % (1 << lvl)) == 0) begin : gCell
        gp_merge uCell (
          .gH(inG[i]),
          .pH(inP[i]),
          .gL(inG[i - (1 << (lvl - 1))]),
          .pL(inP[i - (1 << (lvl - 1))]),
          .G (g[i]),
          .P (p[i])
        );
      end else begin : gCell
        assign g[i] = inG[i];
        assign p[i] = inP[i];
      end
    end
  end

  logic [WIDTH-1:0] upG;
  logic [WIDTH-1:0] upP;

  if (LOG_W == 2) begin : gUpFinal
    assign upG = s1G2_q;
    assign upP = s1P2_q;
  end else begin : gUpFinal
    assign upG = gS2Up[LOG_W].g;
    assign upP = gS2Up[LOG_W].p;
  end

  // ---------------------------------------------------------------------------
  // Stage 2 combinational: down-sweep. Step s works at span 2^(LOG_W-s) and
  // fills the midpoint of each block from the full prefix just below it, so
  // after the last step every node holds the prefix over bits [i:0].
  // ---------------------------------------------------------------------------
  for (genvar s = 1; s < LOG_W; s++) begin : gS2Dn
    localparam int DL = LOG_W - s;
    logic [WIDTH-1:0] inG;
    logic [WIDTH-1:0] inP;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;

    if (s == 1) begin : gSrc
      assign inG = upG;
      assign inP = upP;
    end else begin : gSrc
      assign inG = gS2Dn[s-1].g;
      assign inP = gS2Dn[s-1].p;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : gNode
      if ((((i + 1) % (1 << DL)) == (1 << (DL - 1))) && (i >= (1 << DL))) begin : gCell
        gp_merge uCell (
          .gH(inG[i]),
          .pH(inP[i]),
          .gL(inG[i - (1 << (DL - 1))]),
          .pL(inP[i - (1 << (DL - 1))]),
          .G (g[i]),
          .P (p[i])
        );
      end else begin : gCell
        assign g[i] = inG[i];
        assign p[i] = inP[i];
      end
    end
  end

  logic [WIDTH-1:0] preG;
  logic [WIDTH-1:0] preP;
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] s2Diff;

  assign preG = gS2Dn[LOG_W-1].g;
  assign preP = gS2Dn[LOG_W-1].p;

  // Carry into bit i+1 folds the incoming carry (~Bin) into the bit [i:0] prefix.
  always_comb begin
    carry    = '0;
    carry[0] = s1C0_q;
    for (int i = 0; i < WIDTH; i++) begin
      carry[i+1] = preG[i] | (preP[i] & s1C0_q);
    end
  end

  assign s2Diff = s1P_q ^ carry[WIDTH-1:0];

  // ---------------------------------------------------------------------------
  // Stage 2 registers (the block outputs)
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] d_q, d_d;
  logic             bout_q, bout_d;
  logic             v_q, v_d;

  // Load a finished result when S1 advances; otherwise hold it until consumed.
  always_comb begin
    s2Valid_d = s2Valid_q;
    d_d       = d_q;
    bout_d    = bout_q;
    v_d       = v_q;
    if (s2Load) begin
      s2Valid_d = 1'b1;
      d_d       = s2Diff;
      bout_d    = ~carry[WIDTH];
      v_d       = (s1AMsb_q != s1BMsb_q) && (s2Diff[WIDTH-1] != s1AMsb_q);
    end else if (out_ready) begin
      s2Valid_d = 1'b0;
    end
  end

  // Output stage state; reset discards any in-flight result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2Valid_q <= 1'b0;
      d_q       <= '0;
      bout_q    <= 1'b0;
      v_q       <= 1'b0;
    end else begin
      s2Valid_q <= s2Valid_d;
      d_q       <= d_d;
      bout_q    <= bout_d;
      v_q       <= v_d;
    end
  end

  assign D    = d_q;
  assign Bout = bout_q;
  assign V    = v_q;

endmodule

// File: tb/tb_bk_sub_pipe.sv
// Testbench for bk_sub_pipe: directed corner cases, backpressure and reset
// scenarios, then randomized traffic against an arithmetic reference queue.
module tb_bk_sub_pipe;

  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] D;
  logic         Bout;
  logic         V;

  bk_sub_pipe #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .B        (B),
    .Bin      (Bin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .D        (D),
    .Bout     (Bout),
    .V        (V)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic         v;
    logic         bout;
    logic [W-1:0] d;
  } res_t;

  res_t expQ[$];
  res_t outLog[$];
  int   vecCount = 0;
  int   missCount = 0;
  logic sawOutValid;
  logic sawInReady;
  logic lastAccepted;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Reference: plain integer subtraction, borrow from sign of the unsigned
  // result, overflow from the signed result leaving the 16-bit range.
  function automatic res_t refSub(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
    res_t r;
    int ua, ub, bint, ud, sa, sb, sd;
    ua   = int'(a);
    ub   = int'(b);
    bint = bi ? 1 : 0;
    ud   = ua - ub - bint;
    sa   = int'($signed(a));
    sb   = int'($signed(b));
    sd   = sa - sb - bint;
    r.d    = ud[W-1:0];
    r.bout = (ud < 0);
    r.v    = (sd > 32767) || (sd < -32768);
    return r;
  endfunction

  function automatic logic [W-1:0] pickOperand();
    int sel;
    sel = $urandom_range(0, 15);
    case (sel)
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h8000;
      3:       return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  // One clock cycle: drive after the falling edge, observe before the rising
  // edge, then update the reference queue for whatever handshakes completed.
  task automatic applyStimulus(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic bi, input logic ordy);
    res_t got;
    logic acc;
    logic emit;
    @(negedge clk);
    in_valid  = v;
    A         = a;
    B         = b;
    Bin       = bi;
    out_ready = ordy;
    #1;
    sawOutValid = out_valid;
    sawInReady  = in_ready;
    acc  = in_valid & in_ready;
    emit = out_valid & out_ready;
    got.d    = D;
    got.bout = Bout;
    got.v    = V;
    if (out_valid) begin
      if (expQ.size() == 0) begin
        checkOutput("staleBeat", 32'(out_valid), 32'd0);
      end else begin
        checkOutput("D", 32'(D), 32'(expQ[0].d));
        checkOutput("Bout", 32'(Bout), 32'(expQ[0].bout));
        checkOutput("V", 32'(V), 32'(expQ[0].v));
      end
    end
    @(posedge clk);
    if (emit) begin
      outLog.push_back(got);
      if (expQ.size() > 0) void'(expQ.pop_front());
    end
    if (acc) expQ.push_back(refSub(a, b, bi));
    lastAccepted = acc;
  endtask

  // Hold reset low across one rising edge and check the cleared outputs.
  task automatic doReset();
    @(negedge clk);
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    expQ.delete();
    #1;
    checkOutput("rstOutValid", 32'(out_valid), 32'd0);
    checkOutput("rstInReady", 32'(in_ready), 32'd1);
    checkOutput("rstD", 32'(D), 32'd0);
    checkOutput("rstBout", 32'(Bout), 32'd0);
    checkOutput("rstV", 32'(V), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [W-1:0] dirD[5]    = '{16'h0002, 16'hFFFF, 16'hFFFF, 16'h7FFF, 16'h8000};
  logic         dirBout[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic         dirV[5]    = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [W-1:0] bpD[3]     = '{16'h000F, 16'h001E, 16'h002D};

  initial begin
    int accepted;
    int cycles;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    A         = '0;
    B         = '0;
    Bin       = 1'b0;
    out_ready = 1'b0;
    lastAccepted = 1'b0;
    sawOutValid  = 1'b0;
    sawInReady   = 1'b0;

    $display("[TB] reset state");
    doReset();

    $display("[TB] latency and directed corner vectors");
    outLog.delete();
    applyStimulus(1'b1, 16'h0005, 16'h0003, 1'b0, 1'b1);
    checkOutput("firstAccept", 32'(lastAccepted), 32'd1);
    applyStimulus(1'b1, 16'h0000, 16'h0001, 1'b0, 1'b1);
    checkOutput("latencyNotEarly", 32'(sawOutValid), 32'd0);
    applyStimulus(1'b1, 16'h1234, 16'h1234, 1'b1, 1'b1);
    checkOutput("latencyTwo", 32'(sawOutValid), 32'd1);
    applyStimulus(1'b1, 16'h8000, 16'h0001, 1'b0, 1'b1);
    applyStimulus(1'b1, 16'h7FFF, 16'hFFFF, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
    checkOutput("dirCount", 32'(outLog.size()), 32'd5);
    for (int i = 0; i < 5 && i < outLog.size(); i++) begin
      checkOutput("dirD", 32'(outLog[i].d), 32'(dirD[i]));
      checkOutput("dirBout", 32'(outLog[i].bout), 32'(dirBout[i]));
      checkOutput("dirV", 32'(outLog[i].v), 32'(dirV[i]));
    end

    $display("[TB] backpressure");
    outLog.delete();
    applyStimulus(1'b1, 16'h0010, 16'h0001, 1'b0, 1'b0);
    checkOutput("bp1Accept", 32'(lastAccepted), 32'd1);
    applyStimulus(1'b1, 16'h0020, 16'h0002, 1'b0, 1'b0);
    checkOutput("bp2Accept", 32'(lastAccepted), 32'd1);
    applyStimulus(1'b1, 16'h0030, 16'h0003, 1'b0, 1'b0);
    checkOutput("bp3Blocked", 32'(sawInReady), 32'd0);
    applyStimulus(1'b1, 16'h0030, 16'h0003, 1'b0, 1'b0);
    checkOutput("bpHoldValid", 32'(sawOutValid), 32'd1);
    checkOutput("bpHoldD", 32'(D), 32'h000F);
    applyStimulus(1'b1, 16'h0030, 16'h0003, 1'b0, 1'b1);
    checkOutput("bpRelease1", 32'(sawOutValid), 32'd1);
    checkOutput("bp3Accept", 32'(lastAccepted), 32'd1);
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
    checkOutput("bpRelease2", 32'(sawOutValid), 32'd1);
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
    checkOutput("bpRelease3", 32'(sawOutValid), 32'd1);
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
    checkOutput("bpCount", 32'(outLog.size()), 32'd3);
    for (int i = 0; i < 3 && i < outLog.size(); i++) begin
      checkOutput("bpOrder", 32'(outLog[i].d), 32'(bpD[i]));
    end

    $display("[TB] reset mid-stall");
    applyStimulus(1'b1, 16'h1111, 16'h0001, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h2222, 16'h0002, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    checkOutput("stallFull", 32'(sawInReady), 32'd0);
    doReset();
    outLog.delete();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
      checkOutput("noStale", 32'(sawOutValid), 32'd0);
    end

    $display("[TB] random regression");
    accepted = 0;
    cycles   = 0;
    while (accepted < 10000 && cycles < 60000) begin
      applyStimulus(1'($urandom_range(0, 9) < 7), pickOperand(), pickOperand(),
                    1'($urandom), 1'($urandom_range(0, 9) < 6));
      if (lastAccepted) accepted++;
      cycles++;
    end
    checkOutput("randAccepted", 32'(accepted), 32'd10000);
    cycles = 0;
    while (expQ.size() > 0 && cycles < 20) begin
      applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
      cycles++;
    end
    checkOutput("drainEmpty", 32'(expQ.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
